// File: rtl/note_sequencer.sv
// Writable note-chart sequencer: plays one LANES-bit chart word per beat_tick
// under an IDLE/PLAY/PAUSE/DONE controller with optional looping.
module note_sequencer #(
   parameter int unsigned LANES = 5,
   parameter int unsigned DEPTH = 128,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              beat_tick,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   input  logic [ADDR_W:0]   song_len,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [LANES-1:0]  wr_data,
   output logic [LANES-1:0]  notes,
   output logic              note_valid,
   output logic [ADDR_W-1:0] note_idx,
   output logic              playing,
   output logic              done,
   output logic              wrapped
);

   localparam int unsigned LEN_W = ADDR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

   state_t              state, state_d;
   logic [ADDR_W-1:0]   rd_addr, rd_addr_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LANES-1:0]    notes_d;
   logic [ADDR_W-1:0]   note_idx_d;
   logic                note_valid_d;
   logic                wrapped_d;

   logic [LANES-1:0]    mem [DEPTH];
   logic [LANES-1:0]    rd_word_c;
   logic                last_slot_c;
   logic [LEN_W-1:0]    len_clamped_c;

   // Chart storage: written in any state, never reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Read of the current slot sees the pre-write word on a same-cycle write
   assign rd_word_c     = mem[rd_addr];
   assign last_slot_c   = (LEN_W'(rd_addr) == (len_q - LEN_W'(1)));
   assign len_clamped_c = (song_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : song_len;

   // State, playback pointer and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         rd_addr    <= '0;
         len_q      <= '0;
         notes      <= '0;
         note_idx   <= '0;
         note_valid <= 1'b0;
         wrapped    <= 1'b0;
         playing    <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_d;
         rd_addr    <= rd_addr_d;
         len_q      <= len_d;
         notes      <= notes_d;
         note_idx   <= note_idx_d;
         note_valid <= note_valid_d;
         wrapped    <= wrapped_d;
         playing    <= (state_d == S_PLAY) || (state_d == S_PAUSE);
         done       <= (state_d == S_DONE);
      end
   end

   // Next state: stop > start > pause > beat_tick
   always_comb begin
      state_d      = state;
      rd_addr_d    = rd_addr;
      len_d        = len_q;
      notes_d      = notes;
      note_idx_d   = note_idx;
      note_valid_d = 1'b0;
      wrapped_d    = 1'b0;

      if (stop) begin
         state_d    = S_IDLE;
         rd_addr_d  = '0;
         notes_d    = '0;
         note_idx_d = '0;
      end else if (start) begin
         len_d      = len_clamped_c;
         rd_addr_d  = '0;
         notes_d    = '0;
         note_idx_d = '0;
         state_d    = (len_clamped_c == '0) ? S_DONE : S_PLAY;
      end else begin
         case (state)
            S_PLAY: begin
               if (pause) begin
                  state_d = S_PAUSE;
               end else if (beat_tick) begin
                  notes_d      = rd_word_c;
                  note_idx_d   = rd_addr;
                  note_valid_d = 1'b1;
                  if (!last_slot_c) begin
                     rd_addr_d = rd_addr + ADDR_W'(1);
                  end else if (loop_en) begin
                     rd_addr_d = '0;
                     wrapped_d = 1'b1;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
            S_PAUSE: begin
               if (!pause) begin
                  state_d = S_PLAY;
               end
            end
            S_DONE: begin
               if (beat_tick) begin
                  notes_d = '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a slot-counting model.
module tb_note_sequencer;

   localparam int LANES  = 5;
   localparam int DEPTH  = 128;
   localparam int ADDR_W = 7;

   localparam int M_IDLE  = 0;
   localparam int M_PLAY  = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              beat_tick = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              pause = 1'b0;
   logic              loop_en = 1'b0;
   logic [ADDR_W:0]   song_len = '0;
   logic              wr_en = 1'b0;
   logic [ADDR_W-1:0] wr_addr = '0;
   logic [LANES-1:0]  wr_data = '0;
   logic [LANES-1:0]  notes;
   logic              note_valid;
   logic [ADDR_W-1:0] note_idx;
   logic              playing;
   logic              done;
   logic              wrapped;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   note_sequencer dut (
      .clk(clk), .rst(rst), .beat_tick(beat_tick), .start(start), .stop(stop),
      .pause(pause), .loop_en(loop_en), .song_len(song_len), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .notes(notes), .note_valid(note_valid),
      .note_idx(note_idx), .playing(playing), .done(done), .wrapped(wrapped)
   );

   always #5 clk = ~clk;

   // Reference model: a slot counter walking a plain array copy of the chart
   int mode = M_IDLE;
   int pos = 0;
   int len = 0;
   int e_notes = 0, e_idx = 0, e_valid = 0, e_wrap = 0;
   int chart [DEPTH];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mode = M_IDLE; pos = 0; len = 0;
         e_notes = 0; e_idx = 0; e_valid = 0; e_wrap = 0;
      end else begin
         e_valid = 0;
         e_wrap  = 0;
         if (stop) begin
            mode = M_IDLE; pos = 0; e_notes = 0; e_idx = 0;
         end else if (start) begin
            len = (int'(song_len) > DEPTH) ? DEPTH : int'(song_len);
            pos = 0; e_notes = 0; e_idx = 0;
            mode = (len == 0) ? M_DONE : M_PLAY;
         end else if (mode == M_PLAY && pause) begin
            mode = M_PAUSE;
         end else if (mode == M_PAUSE && !pause) begin
            mode = M_PLAY;
         end else if (mode == M_PLAY && beat_tick) begin
            e_notes = chart[pos];
            e_idx   = pos;
            e_valid = 1;
            pos     = pos + 1;
            if (pos == len) begin
               if (loop_en) begin
                  pos = 0;
                  e_wrap = 1;
               end else begin
                  mode = M_DONE;
               end
            end
         end else if (mode == M_DONE && beat_tick) begin
            e_notes = 0;
         end
         if (wr_en) chart[int'(wr_addr)] = int'(wr_data);
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      if (!rst && cmp_en) begin
         checks++;
         if (int'(notes) != e_notes || int'(note_valid) != e_valid ||
             int'(note_idx) != e_idx || int'(wrapped) != e_wrap ||
             int'(playing) != int'(mode == M_PLAY || mode == M_PAUSE) ||
             int'(done) != int'(mode == M_DONE)) begin
            failures++;
            $display("FAIL model_cmp t=%0t act notes=%h v=%0d idx=%0d wr=%0d pl=%0d dn=%0d exp notes=%h v=%0d idx=%0d wr=%0d pl=%0d dn=%0d",
                     $time, notes, note_valid, note_idx, wrapped, playing, done,
                     e_notes, e_valid, e_idx, e_wrap,
                     int'(mode == M_PLAY || mode == M_PAUSE), int'(mode == M_DONE));
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // One clock: inputs set by caller are applied, then pulses drop
   task automatic cyc();
      @(negedge clk);
      start = 1'b0; stop = 1'b0; beat_tick = 1'b0; wr_en = 1'b0;
   endtask

   task automatic tick();
      beat_tick = 1'b1;
      cyc();
   endtask

   task automatic go(input int n, input bit lp);
      song_len = (ADDR_W+1)'(n);
      loop_en  = lp;
      start    = 1'b1;
      cyc();
   endtask

   logic [LANES-1:0] w [4];
   int nv;

   initial begin
      w[0] = 5'h01; w[1] = 5'h04; w[2] = 5'h10; w[3] = 5'h08;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      chk("reset_notes", int'(notes), 0);
      chk("reset_playing", int'(playing), 0);
      chk("reset_done", int'(done), 0);

      // Fill whole chart, then place the directed words
      for (int a = 0; a < DEPTH; a++) begin
         wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = LANES'($urandom);
         cyc();
      end
      for (int a = 0; a < 4; a++) begin
         wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = w[a];
         cyc();
      end

      // 1: single pass
      go(4, 1'b0);
      chk("t1_playing", int'(playing), 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_notes", int'(notes), int'(w[i]));
         chk("t1_idx", int'(note_idx), i);
         chk("t1_valid", int'(note_valid), 1);
      end
      chk("t1_done", int'(done), 1);
      tick();
      chk("t1_clear_notes", int'(notes), 0);
      chk("t1_clear_valid", int'(note_valid), 0);

      // 2: loop mode
      go(4, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t2_notes", int'(notes), int'(w[i % 4]));
         chk("t2_wrapped", int'(wrapped), int'(i == 3));
         chk("t2_done", int'(done), 0);
      end

      // 3: pause
      go(4, 1'b0);
      tick(); tick();
      pause = 1'b1;
      tick();
      chk("t3_pause_edge_valid", int'(note_valid), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_paused_valid", int'(note_valid), 0);
      end
      pause = 1'b0;
      cyc();
      tick();
      chk("t3_resume_notes", int'(notes), 16);
      chk("t3_resume_idx", int'(note_idx), 2);

      // 4: stop priority, zero length, clamped length
      stop = 1'b1; start = 1'b1; beat_tick = 1'b1;
      cyc();
      chk("t4_stop_playing", int'(playing), 0);
      chk("t4_stop_notes", int'(notes), 0);
      chk("t4_stop_valid", int'(note_valid), 0);
      go(0, 1'b0);
      chk("t4_zero_done", int'(done), 1);
      go(DEPTH + 1, 1'b0);
      nv = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
         tick();
         nv += int'(note_valid);
      end
      chk("t4_clamped_slots", nv, DEPTH);
      chk("t4_clamped_done", int'(done), 1);

      // 5: asynchronous reset mid-play, chart survives
      go(4, 1'b0);
      tick(); tick();
      chk("t5_pre_rst_notes", int'(notes), 4);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_notes", int'(notes), 0);
      chk("t5_rst_idx", int'(note_idx), 0);
      chk("t5_rst_playing", int'(playing), 0);
      #1 rst = 1'b0;
      @(negedge clk);
      go(4, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_chart_kept", int'(notes), int'(w[i]));
      end

      // 6: write to the slot being read
      go(4, 1'b1);
      tick(); tick();
      wr_en = 1'b1; wr_addr = ADDR_W'(2); wr_data = 5'h1F;
      tick();
      chk("t6_old_word", int'(notes), 16);
      tick(); tick(); tick(); tick();
      chk("t6_new_word", int'(notes), 31);
      stop = 1'b1;
      cyc();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         int r;
         stop      = ($urandom_range(99) < 2);
         start     = ($urandom_range(99) < 4);
         beat_tick = ($urandom_range(99) < 50);
         if ($urandom_range(99) < 6) pause = ~pause;
         if ($urandom_range(99) < 10) loop_en = ~loop_en;
         r = $urandom_range(9);
         if (r == 0) song_len = '0;
         else if (r == 1) song_len = (ADDR_W+1)'($urandom_range(255));
         else song_len = (ADDR_W+1)'($urandom_range(8, 1));
         wr_en   = ($urandom_range(99) < 15);
         wr_addr = ADDR_W'($urandom_range(DEPTH - 1));
         wr_data = LANES'($urandom);
         cyc();
      end
      pause = 1'b0;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
